unidade_busca: RTL and testbench
================================

Name: unidade_busca

Overview:
Instruction fetch stage directly upstream of the multicycle control unit. It holds the PC, fetches 16-bit instructions over a req/ack instruction-memory handshake, latches them into the IR, and exposes the decoded fields (opcode to the control FSM, register/immediate fields to the datapath). It also computes the next PC from the control signals EscCP, EscCondCP and FonteCP plus the ALU zero flag. A watchdog halts fetch if memory stops acknowledging.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before error (1..2^TO_W-1)
TO_W, 4, watchdog counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
mem_req  out  1  instruction read request
mem_addr  out  ADDR_W  read address, equals pc
mem_ack  in  1  read data valid this cycle
mem_rdata  in  16  instruction word
EscCP  in  1  unconditional PC write (from control)
EscCondCP  in  1  conditional PC write, qualified by zero
FonteCP  in  2  next-PC source: 00 PC+1, 01 branch, 10 jump, 11 PC+1
zero  in  1  ALU zero flag
ir_valid  out  1  IR holds a fetched, not-yet-retired instruction
opcode  out  4  ir[15:12]
rd  out  4  ir[11:8]
rs  out  4  ir[7:4]
rt  out  4  ir[3:0]
imm  out  8  ir[7:0]
pc  out  ADDR_W  current PC
fetch_err  out  1  sticky watchdog error

Behaviour:
- Reset (rst==0 at posedge, overrides everything incl. mid-fetch): pc=0, ir=16'h0000, state=FETCH, ir_valid=0, fetch_err=0, watchdog=0. mem_req is high in the first cycle after reset release, because state=FETCH.
- States: FETCH, HOLD, ERR.
- FETCH: mem_req=1 (combinational from state), mem_addr=pc stable. On mem_ack: ir<=mem_rdata, ir_valid<=1, watchdog<=0, go to HOLD. An ack in the first FETCH cycle is legal, giving 1-cycle fetch latency. Without ack, watchdog increments. When watchdog==TIMEOUT-1 and there is still no ack: fetch_err<=1, go to ERR.
- FETCH ignores EscCP/EscCondCP: pc is not changed.
- HOLD: mem_req=0, ir_valid=1. Effective write pcw = EscCP | (EscCondCP & zero). On pcw: pc<=next_pc, ir_valid<=0, go to FETCH. Otherwise hold with ir and pc unchanged.
- EscCondCP with zero=0 and EscCP=0: no PC change, stay in HOLD (branch not taken is retired by control via EscCP).
- ERR: mem_req=0, ir_valid=0, pc/ir frozen, fetch_err=1. Only reset exits.
- next_pc arithmetic is modulo 2^ADDR_W with wrap-around, no overflow flag:
  - 00/11: pc+1
  - 01: pc+1+sign_extend(imm[7:0]) to ADDR_W; when ADDR_W<8, truncate the sum to ADDR_W
  - 10: ir[11:0] truncated or zero-extended to ADDR_W
- Field outputs are combinational from ir; they stay valid (stable) whenever ir_valid=1. They hold the previous IR while ir_valid=0.
- mem_ack outside FETCH is ignored.

Test Plan:
- Reset then mem_ack on 1st FETCH cycle with rdata=16'h0123 -> mem_addr=0; next cycle ir_valid=1, opcode=0, rd=1, rs=2, rt=3.
- In HOLD with pc=5, EscCP=1, FonteCP=00 for one cycle -> pc=6, ir_valid=0, mem_req=1, mem_addr=6.
- Branch at pc=10 with imm=8'hFC: EscCondCP=1, FonteCP=01, zero=1 -> pc=7. Same with zero=0, EscCP=0 -> pc stays 10, HOLD kept.
- Jump: ir=16'hB0F3, EscCP=1, FonteCP=10, ADDR_W=8 -> pc=8'hF3. Separately, pc=8'hFF with EscCP=1, FonteCP=00 -> pc=0.
- mem_ack withheld for TIMEOUT=15 cycles -> fetch_err=1 after 15th FETCH cycle, mem_req=0. A late ack at cycle 20 has no effect, and only rst=0 clears the error.
- rst=0 asserted while in FETCH with mem_ack pending -> next cycle pc=0, ir_valid=0, ir=0. The ack arriving in the reset cycle is not captured.

Source files
------------

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage feeding the multicycle control unit.
//
// Holds the PC, fetches 16-bit instructions over a req/ack memory handshake,
// latches them into the IR and exposes the decoded fields. The next PC is
// selected from EscCP / EscCondCP / FonteCP and the ALU zero flag. A watchdog
// parks the stage in a sticky error state if memory stops acknowledging.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   mem_req, mem_addr   instruction read request / address (always pc)
//   mem_ack, mem_rdata  read data strobe / instruction word
//   EscCP, EscCondCP    unconditional / zero-qualified PC write
//   FonteCP             next-PC source: 00 pc+1, 01 branch, 10 jump, 11 pc+1
//   zero                ALU zero flag
//   ir_valid            IR holds a fetched, not-yet-retired instruction
//   opcode, rd, rs, rt  IR fields [15:12], [11:8], [7:4], [3:0]
//   imm                 IR field [7:0]
//   pc                  current PC
//   fetch_err           sticky watchdog error
//
// state | meaning
// FETCH | mem_req high, waiting for mem_ack; watchdog counting
// HOLD  | IR valid, waiting for control to write the PC
// ERR   | memory never answered; frozen until reset

module unidade_busca #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              EscCP,
  input  logic              EscCondCP,
  input  logic [1:0]        FonteCP,
  input  logic              zero,
  output logic              ir_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;

  state_t            state, state_nx;
  logic [15:0]       ir;
  logic [TO_W-1:0]   wd;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm_ext;
  logic              pcw;
  logic              ir_load;
  logic              pc_load;
  logic              wd_clr;
  logic              wd_inc;
  logic              err_set;

  assign opcode   = ir[15:12];
  assign rd       = ir[11:8];
  assign rs       = ir[7:4];
  assign rt       = ir[3:0];
  assign imm      = ir[7:0];
  assign mem_addr = pc;
  assign ir_valid = (state == HOLD);
  assign pcw      = EscCP | (EscCondCP & zero);

  // Sized cast of a signed value sign-extends or truncates to ADDR_W.
  assign pc_inc  = pc + ADDR_W'(1);
  assign imm_ext = ADDR_W'(signed'(ir[7:0]));

  always_comb begin
    next_pc = pc_inc;
    case (FonteCP)
      2'b01:   next_pc = pc_inc + imm_ext;
      2'b10:   next_pc = ADDR_W'(ir[11:0]);
      default: next_pc = pc_inc;
    endcase
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    err_set  = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load  = 1'b1;
          wd_clr   = 1'b1;
          state_nx = HOLD;
        end else if (wd == TO_W'(TIMEOUT - 1)) begin
          err_set  = 1'b1;
          state_nx = ERR;
        end else begin
          wd_inc = 1'b1;
        end
      end
      HOLD: begin
        if (pcw) begin
          pc_load  = 1'b1;
          state_nx = FETCH;
        end
      end
      ERR:     state_nx = ERR;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      wd        <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_load) ir <= mem_rdata;
      if (pc_load) pc <= next_pc;
      if (wd_clr)      wd <= '0;
      else if (wd_inc) wd <= wd + TO_W'(1);
      if (err_set) fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
module tb_unidade_busca;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              EscCP, EscCondCP, zero;
  logic [1:0]        FonteCP;
  logic              ir_valid;
  logic [3:0]        opcode, rd, rs, rt;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  unidade_busca #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .EscCP(EscCP),
    .EscCondCP(EscCondCP), .FonteCP(FonteCP), .zero(zero),
    .ir_valid(ir_valid), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
  } item_t;

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch pops one expectation; the following cycle
  // the IR fields must reflect the expected word.
  item_t cur;
  bit    pend = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        chk("sb_ir_valid", 32'(ir_valid), 32'd1);
        chk("sb_opcode", 32'(opcode), 32'(cur.word[15:12]));
        chk("sb_rd",     32'(rd),     32'(cur.word[11:8]));
        chk("sb_rs",     32'(rs),     32'(cur.word[7:4]));
        chk("sb_rt",     32'(rt),     32'(cur.word[3:0]));
        chk("sb_imm",    32'(imm),    32'(cur.word[7:0]));
      end
      if (rst && mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_fetch", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          cur = exp_q.pop_front();
          chk("sb_mem_addr", 32'(mem_addr), 32'(cur.addr));
          pend = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the stage is in FETCH; withholds ack for lat cycles.
  task automatic do_fetch(input logic [7:0] addr, input logic [15:0] word, input int lat);
    item_t it;
    it.addr = addr;
    it.word = word;
    chk("fetch_req", 32'(mem_req), 32'd1);
    exp_q.push_back(it);
    for (int i = 0; i < lat; i++) tick();
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  task automatic pc_write(input logic e, input logic ec, input logic [1:0] f, input logic z);
    EscCP = e; EscCondCP = ec; FonteCP = f; zero = z;
    tick();
    EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'b00; zero = 1'b0;
  endtask

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    EscCP = 1'b0; EscCondCP = 1'b0; FonteCP = 2'b00; zero = 1'b0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    rst = 1'b1;
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd0);

    // 1-cycle fetch right after reset
    do_fetch(8'd0, 16'h0123, 0);
    chk("hold_req_low", 32'(mem_req), 32'd0);
    chk("first_rd", 32'(rd), 32'd1);

    // ack while holding must be ignored
    mem_ack = 1'b1; mem_rdata = 16'hEEEE;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("hold_ack_ignored", 32'(opcode), 32'd0);
    chk("hold_ir_valid", 32'(ir_valid), 32'd1);

    pc_write(1, 0, 2'b00, 0);            // pc 0 -> 1
    chk("inc_pc1", 32'(pc), 32'd1);
    do_fetch(8'd1, 16'hB005, 2);
    pc_write(1, 0, 2'b10, 0);            // jump -> 5
    chk("jump_pc5", 32'(pc), 32'd5);
    do_fetch(8'd5, 16'h1234, 1);
    pc_write(1, 0, 2'b00, 0);            // 5 -> 6
    chk("inc_pc6", 32'(pc), 32'd6);
    chk("inc_ir_valid", 32'(ir_valid), 32'd0);
    chk("inc_req", 32'(mem_req), 32'd1);
    chk("inc_addr", 32'(mem_addr), 32'd6);
    do_fetch(8'd6, 16'hB00A, 0);
    pc_write(1, 0, 2'b10, 0);            // jump -> 10
    do_fetch(8'd10, 16'h21FC, 0);

    // branch not taken: stays in HOLD at pc 10
    pc_write(0, 1, 2'b01, 0);
    chk("br_nt_pc", 32'(pc), 32'd10);
    chk("br_nt_ir_valid", 32'(ir_valid), 32'd1);
    chk("br_nt_req", 32'(mem_req), 32'd0);
    pc_write(0, 1, 2'b01, 1);            // 10 + 1 - 4 = 7
    chk("br_t_pc", 32'(pc), 32'd7);

    do_fetch(8'd7, 16'hB0F3, 3);
    pc_write(1, 0, 2'b10, 0);
    chk("jump_pcF3", 32'(pc), 32'hF3);
    do_fetch(8'hF3, 16'hB0FF, 1);
    pc_write(1, 0, 2'b10, 0);
    chk("jump_pcFF", 32'(pc), 32'hFF);
    do_fetch(8'hFF, 16'h3456, 0);
    pc_write(1, 0, 2'b00, 0);            // wrap FF -> 0
    chk("wrap_pc0", 32'(pc), 32'd0);
    do_fetch(8'd0, 16'h4000, 0);
    pc_write(1, 0, 2'b11, 0);            // source 11 is pc+1
    chk("src11_pc1", 32'(pc), 32'd1);
    do_fetch(8'd1, 16'h5003, 0);
    pc_write(0, 1, 2'b01, 1);            // 1 + 1 + 3 = 5
    chk("br_fwd_pc5", 32'(pc), 32'd5);

    // watchdog: no ack
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("wd_no_err_yet", 32'(fetch_err), 32'd0);
    chk("wd_req_still", 32'(mem_req), 32'd1);
    tick();
    chk("wd_err", 32'(fetch_err), 32'd1);
    chk("wd_req_low", 32'(mem_req), 32'd0);
    chk("wd_ir_valid", 32'(ir_valid), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;  // late ack in cycle 20
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    pc_write(1, 0, 2'b00, 0);
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_pc_frozen", 32'(pc), 32'd5);
    chk("err_ir_frozen", 32'(opcode), 32'd5);
    chk("err_ir_valid", 32'(ir_valid), 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("err_clr", 32'(fetch_err), 32'd0);
    chk("err_clr_pc", 32'(pc), 32'd0);
    chk("err_clr_req", 32'(mem_req), 32'd1);

    // reset during a fetch with an ack in the same cycle
    do_fetch(8'd0, 16'h6789, 0);
    pc_write(1, 0, 2'b00, 0);            // now fetching at pc 1
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hABCD;
    tick();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_ir_valid", 32'(ir_valid), 32'd0);
    chk("midrst_ir", {16'h0, opcode, rd, rs, rt}, 32'h0000);
    chk("midrst_req", 32'(mem_req), 32'd1);
    do_fetch(8'd0, 16'h0123, 1);
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_pend", 32'(pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
